seven_segment_chain_sequencer: RTL and testbench

SEVEN_SEGMENT_CHAIN_SEQUENCER -- requirements
Module: seven_segment_chain_sequencer

---
 rtl/seven_segment_chain_sequencer_pkg.sv | 32 +++
 rtl/seven_segment_chain_sequencer_if.sv | 41 ++++
 rtl/seven_segment_chain_sequencer_hex_decoder.sv | 15 +
 rtl/seven_segment_chain_sequencer.sv | 129 ++++++++++++
 tb/tb_seven_segment_chain_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_chain_sequencer_pkg.sv
// Shared definitions for the seven-segment chain sequencer:
//   - FSM state encoding
//   - slave register address constants and digit field layout
//   - hex-to-segment lookup table and byte encoder helper
package seven_segment_chain_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam int unsigned MAX_DIGITS  = 8;
    localparam logic [3:0]  ADDR_CTRL   = 4'd8;
    localparam logic [3:0]  ADDR_STATUS = 4'd9;

    // DIGITn field layout: [3:0] hex value, [4] blank, [5] decimal point
    localparam logic [5:0]  DIGIT_RESET = 6'h10;

    // Segments g..a, active-high, indexed by hex value
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Segment byte: bit7 = dp, bits[6:0] = segments; blank clears segments only
    function automatic logic [7:0] seg_encode(input logic [5:0] digit);
        return {digit[5], digit[4] ? 7'h00 : SEG_LUT[digit[3:0]]};
    endfunction

endpackage

// File: rtl/seven_segment_chain_sequencer_if.sv
// Bus bundle for the sequencer: the Avalon-MM slave register port (avs_s0_*)
// and the Avalon-MM master port that shifts segment bytes down the chain
// (avm_m0_*).
//   modport slave  : the sequencer's view (serves avs_s0, drives avm_m0)
//   modport master : the surrounding system's view (host + downstream chain)
interface seven_segment_chain_sequencer_if;

    logic        avs_s0_chipselect;
    logic        avs_s0_write;
    logic        avs_s0_read;
    logic [3:0]  avs_s0_address;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;
    logic        avs_s0_waitrequest;

    logic        avm_m0_chipselect;
    logic        avm_m0_write;
    logic [3:0]  avm_m0_byteenable;
    logic [31:0] avm_m0_writedata;
    logic [7:0]  avm_m0_address;
    logic        avm_m0_waitrequest;

    modport slave (
        input  avs_s0_chipselect, avs_s0_write, avs_s0_read,
        input  avs_s0_address, avs_s0_writedata,
        output avs_s0_readdata, avs_s0_waitrequest,
        output avm_m0_chipselect, avm_m0_write, avm_m0_byteenable,
        output avm_m0_writedata, avm_m0_address,
        input  avm_m0_waitrequest
    );

    modport master (
        output avs_s0_chipselect, avs_s0_write, avs_s0_read,
        output avs_s0_address, avs_s0_writedata,
        input  avs_s0_readdata, avs_s0_waitrequest,
        input  avm_m0_chipselect, avm_m0_write, avm_m0_byteenable,
        input  avm_m0_writedata, avm_m0_address,
        output avm_m0_waitrequest
    );

endinterface

// File: rtl/seven_segment_chain_sequencer_hex_decoder.sv
// Combinational hex-to-segment decoder.
//   digit : {dp, blank, hex[3:0]}
//   seg   : {dp, g, f, e, d, c, b, a}, active-high
module seven_segment_hex_decoder
    import seven_segment_chain_sequencer_pkg::*;
(
    input  logic [5:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = seg_encode(digit);
    end

endmodule

// File: rtl/seven_segment_chain_sequencer.sv
// Seven-segment chain sequencer. Host writes DIGITn registers over avs_s0;
// a pass (host start or auto-refresh) snapshots them and shifts one decoded
// segment byte per transfer out of avm_m0, highest digit first.
//   clock, resetn : single clock, asynchronous active-low reset
//   bus           : avs_s0 register slave + avm_m0 chain master (slave modport)
module seven_segment_chain_sequencer
    import seven_segment_chain_sequencer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic                            clock,
    input  logic                            resetn,
    seven_segment_chain_sequencer_if.slave  bus
);

    state_t      state, next_state;
    logic [5:0]  digit  [NUM_DIGITS];
    logic [5:0]  shadow [NUM_DIGITS];
    logic [2:0]  idx;
    logic        auto_en;
    logic        st_done;
    logic        st_overrun;
    logic [31:0] refresh_cnt;
    logic [7:0]  seg_byte;

    logic wr_sel, start_req, sts_wr, refresh_exp, xfer_ok, last_xfer, busy;

    assign wr_sel      = bus.avs_s0_chipselect && bus.avs_s0_write;
    assign start_req   = wr_sel && (bus.avs_s0_address == ADDR_CTRL) && bus.avs_s0_writedata[0];
    assign sts_wr      = wr_sel && (bus.avs_s0_address == ADDR_STATUS);
    assign refresh_exp = (state == ST_IDLE) && auto_en && (refresh_cnt == '0);
    assign xfer_ok     = (state == ST_XFER) && !bus.avm_m0_waitrequest;
    assign last_xfer   = xfer_ok && (idx == '0);
    assign busy        = (state != ST_IDLE);

    seven_segment_hex_decoder u_dec (
        .digit (shadow[idx]),
        .seg   (seg_byte)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_req || refresh_exp) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_XFER;
            ST_XFER: if (last_xfer) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Chain master outputs decode straight from state so reset drops them at once
    always_comb begin
        bus.avm_m0_chipselect = (state == ST_XFER);
        bus.avm_m0_write      = (state == ST_XFER);
        bus.avm_m0_byteenable = (state == ST_XFER) ? 4'b0001 : 4'b0000;
        bus.avm_m0_writedata  = (state == ST_XFER) ? {24'd0, seg_byte} : '0;
        bus.avm_m0_address    = '0;
    end

    // Host registers; done is raised on the last transfer's completion edge so
    // it reads back as 1 during the DONE cycle itself
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digit[i] <= DIGIT_RESET;
            auto_en    <= 1'b0;
            st_done    <= 1'b0;
            st_overrun <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (wr_sel && (bus.avs_s0_address == 4'(i)))
                    digit[i] <= bus.avs_s0_writedata[5:0];
            end
            if (wr_sel && (bus.avs_s0_address == ADDR_CTRL))
                auto_en <= bus.avs_s0_writedata[1];
            if (last_xfer)
                st_done <= 1'b1;
            else if (sts_wr && bus.avs_s0_writedata[1])
                st_done <= 1'b0;
            if (start_req && busy)
                st_overrun <= 1'b1;
            else if (sts_wr && bus.avs_s0_writedata[2])
                st_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
            idx <= '0;
        end else if (state == ST_LOAD) begin
            shadow <= digit;
            idx    <= 3'(NUM_DIGITS - 1);
        end else if (xfer_ok && (idx != '0)) begin
            idx <= idx - 3'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            refresh_cnt <= 32'(REFRESH_CYCLES - 1);
        else if (!auto_en || start_req || refresh_exp)
            refresh_cnt <= 32'(REFRESH_CYCLES - 1);
        else if (state == ST_IDLE)
            refresh_cnt <= refresh_cnt - 32'd1;
    end

    always_comb begin
        bus.avs_s0_readdata    = '0;
        bus.avs_s0_waitrequest = 1'b0;
        if (resetn && bus.avs_s0_chipselect && bus.avs_s0_read) begin
            if (bus.avs_s0_address == ADDR_CTRL)
                bus.avs_s0_readdata = {30'd0, auto_en, 1'b0};
            else if (bus.avs_s0_address == ADDR_STATUS)
                bus.avs_s0_readdata = {29'd0, st_overrun, st_done, busy};
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (bus.avs_s0_address == 4'(i))
                    bus.avs_s0_readdata = {26'd0, digit[i]};
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_chain_sequencer.sv
// Self-checking bench for seven_segment_chain_sequencer (directed vectors).
module tb_seven_segment_chain_sequencer;
    import seven_segment_chain_sequencer_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    seven_segment_chain_sequencer_if bus ();

    seven_segment_chain_sequencer #(
        .NUM_DIGITS     (8),
        .REFRESH_CYCLES (16)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Chain monitor: every write cycle, completed transfers, pass start cycles
    logic [7:0] all_q[$];
    logic [7:0] done_q[$];
    int         starts[$];
    int         last_wr = -100;

    always @(negedge clock) begin
        if (bus.avm_m0_write) begin
            all_q.push_back(bus.avm_m0_writedata[7:0]);
            if (!bus.avm_m0_waitrequest) begin
                done_q.push_back(bus.avm_m0_writedata[7:0]);
                if (last_wr != cyc - 1) starts.push_back(cyc);
                last_wr = cyc;
            end
        end
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_b [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        bus.avs_s0_chipselect = 1'b1;
        bus.avs_s0_write      = 1'b1;
        bus.avs_s0_address    = a;
        bus.avs_s0_writedata  = d;
        tick();
        bus.avs_s0_chipselect = 1'b0;
        bus.avs_s0_write      = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        bus.avs_s0_chipselect = 1'b1;
        bus.avs_s0_read       = 1'b1;
        bus.avs_s0_address    = a;
        @(negedge clock);
        d = bus.avs_s0_readdata;
        tick();
        bus.avs_s0_chipselect = 1'b0;
        bus.avs_s0_read       = 1'b0;
    endtask

    task automatic clear_mon();
        all_q.delete();
        done_q.delete();
        starts.delete();
    endtask

    // Start a pass and poll STATUS each cycle; returns cycles from start write to done
    task automatic start_and_poll(input bit stall, output int dc);
        logic [31:0] v;
        int s, c;
        bit got;
        s = cyc;
        write_reg(ADDR_CTRL, 32'h1);
        got = 1'b0;
        dc = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            c = cyc;
            bus.avm_m0_waitrequest = stall && (c - s >= 3) && (c - s <= 5);
            read_reg(ADDR_STATUS, v);
            if (v[1]) begin
                got = 1'b1;
                dc = c - s;
            end
        end
        bus.avm_m0_waitrequest = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done never set within 40 cycles");
        end
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, done_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_byte%0d", tag, i), (done_q.size() > i) ? done_q[i] : 8'hxx, exp_b[i]);
    endtask

    initial begin
        logic [31:0] rd;
        int dc, a;

        bus.avs_s0_chipselect  = 1'b0;
        bus.avs_s0_write       = 1'b0;
        bus.avs_s0_read        = 1'b0;
        bus.avs_s0_address     = '0;
        bus.avs_s0_writedata   = '0;
        bus.avm_m0_waitrequest = 1'b0;

        vecs[0] = '{4'd0,  32'h0000_002A, 32'h0000_002A};
        vecs[1] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_003F};
        vecs[2] = '{4'd3,  32'h0000_0015, 32'h0000_0015};
        vecs[3] = '{4'd8,  32'h0000_0002, 32'h0000_0002};
        vecs[4] = '{4'd8,  32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{4'd15, 32'h0000_0011, 32'h0000_0000};
        vecs[7] = '{4'd9,  32'h0000_0007, 32'h0000_0000};

        repeat (3) tick();
        check("rst_readdata", bus.avs_s0_readdata, 32'h0);
        resetn = 1'b1;
        tick();

        // Reset state
        check("rst_avm_write", {31'd0, bus.avm_m0_write}, 32'h0);
        check("rst_avm_be", {28'd0, bus.avm_m0_byteenable}, 32'h0);
        check("rst_avs_wait", {31'd0, bus.avs_s0_waitrequest}, 32'h0);
        read_reg(4'd0, rd);  check("rst_digit0", rd, 32'h10);
        read_reg(4'd5, rd);  check("rst_digit5", rd, 32'h10);
        read_reg(ADDR_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
        read_reg(ADDR_STATUS, rd); check("rst_status", rd, 32'h0);

        // Register map vectors
        for (int i = 0; i < 8; i++) begin
            write_reg(vecs[i].addr, vecs[i].wdata);
            read_reg(vecs[i].addr, rd);
            check($sformatf("regvec%0d", i), rd, vecs[i].exp_rd);
        end

        // Basic pass: DIGITn = n
        for (int i = 0; i < 8; i++) write_reg(4'(i), 32'(i));
        exp_b[0] = 8'h07; exp_b[1] = 8'h7D; exp_b[2] = 8'h6D; exp_b[3] = 8'h66;
        exp_b[4] = 8'h4F; exp_b[5] = 8'h5B; exp_b[6] = 8'h06; exp_b[7] = 8'h3F;
        clear_mon();
        start_and_poll(1'b0, dc);
        check("pass_done_cycle", dc, 10);
        check_bytes("pass");
        check("pass_no_stall_cycles", all_q.size(), 8);
        write_reg(ADDR_STATUS, 32'h2);
        read_reg(ADDR_STATUS, rd); check("done_cleared", rd, 32'h0);

        // Stall 3 cycles on the 2nd transfer
        clear_mon();
        start_and_poll(1'b1, dc);
        check("stall_done_cycle", dc, 13);
        check_bytes("stall");
        check("stall_write_cycles", all_q.size(), 11);
        for (int i = 1; i <= 4; i++)
            check($sformatf("stall_hold%0d", i), (all_q.size() > i) ? all_q[i] : 8'hxx, 8'h7D);
        write_reg(ADDR_STATUS, 32'h2);

        // Second start 2 cycles after the first is dropped and flags overrun
        clear_mon();
        write_reg(ADDR_CTRL, 32'h1);
        tick();
        write_reg(ADDR_CTRL, 32'h1);
        repeat (20) tick();
        check("ovr_count", done_q.size(), 8);
        read_reg(ADDR_STATUS, rd); check("ovr_status", rd, 32'h6);
        write_reg(ADDR_STATUS, 32'h4);
        read_reg(ADDR_STATUS, rd); check("ovr_cleared", rd, 32'h2);
        write_reg(ADDR_STATUS, 32'h2);

        // Blank + dp on DIGIT3
        write_reg(4'd3, 32'h38);
        exp_b[4] = 8'h80;
        clear_mon();
        start_and_poll(1'b0, dc);
        check("blank_done_cycle", dc, 10);
        check_bytes("blank");
        write_reg(ADDR_STATUS, 32'h2);

        // Reset during the 4th transfer
        write_reg(4'd3, 32'h3);
        clear_mon();
        write_reg(ADDR_CTRL, 32'h1);
        repeat (4) tick();
        check("pre_rst_write", {31'd0, bus.avm_m0_write}, 32'h1);
        check("pre_rst_data", bus.avm_m0_writedata, 32'h66);
        resetn = 1'b0;
        #1;
        check("mid_rst_write", {31'd0, bus.avm_m0_write}, 32'h0);
        check("mid_rst_cs", {31'd0, bus.avm_m0_chipselect}, 32'h0);
        check("mid_rst_data", bus.avm_m0_writedata, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        read_reg(4'd0, rd); check("post_rst_digit0", rd, 32'h10);
        read_reg(4'd7, rd); check("post_rst_digit7", rd, 32'h10);
        read_reg(ADDR_STATUS, rd); check("post_rst_status", rd, 32'h0);
        check("post_rst_writes", done_q.size(), 3);

        // Auto-refresh; a start lands exactly on the first expiry
        clear_mon();
        a = cyc;
        write_reg(ADDR_CTRL, 32'h2);
        while (cyc < a + 16) tick();
        write_reg(ADDR_CTRL, 32'h3);
        repeat (70) tick();
        write_reg(ADDR_CTRL, 32'h0);
        repeat (12) tick();
        check("auto_passes_ge3", {31'd0, starts.size() >= 3}, 32'h1);
        check("auto_first_start", (starts.size() > 0) ? starts[0] - a : -1, 18);
        check("auto_gap1", (starts.size() > 1) ? starts[1] - starts[0] : -1, 26);
        check("auto_gap2", (starts.size() > 2) ? starts[2] - starts[1] : -1, 26);
        read_reg(ADDR_STATUS, rd); check("auto_status", rd, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
